// File: rtl/seg_digit_encoder.sv
// Binary-to-seven-segment encoder: iterative double-dabble into five BCD digits,
// then all five digit codes are registered together with optional leading-zero blanking.
`timescale 1ns/1ps
module seg_digit_encoder #(
    parameter bit BLANK_LZ       = 1'b1,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] value,
    input  logic        load,
    output logic        busy,
    output logic        done,
    output logic [7:0]  seg0,
    output logic [7:0]  seg1,
    output logic [7:0]  seg2,
    output logic [7:0]  seg3,
    output logic [7:0]  seg4
);

    localparam int unsigned BIN_W  = 16;
    localparam int unsigned DIGITS = 5;
    localparam int unsigned BCD_W  = 4 * DIGITS;
    localparam int unsigned CNT_W  = 5;
    localparam int unsigned SEG_W  = 8;
    localparam logic [SEG_W-1:0] SEG_OFF = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;

    typedef enum logic [1:0] {IDLE, SHIFT, ENC} state_t;

    state_t           state, state_nxt;
    logic [BIN_W-1:0] bin_q, bin_nxt;
    logic [BCD_W-1:0] bcd_q, bcd_nxt, bcd_adj;
    logic [CNT_W-1:0] cnt_q, cnt_nxt;
    logic             busy_nxt, done_nxt;
    logic [SEG_W-1:0] seg_q   [DIGITS];
    logic [SEG_W-1:0] seg_nxt [DIGITS];
    logic [SEG_W-1:0] enc_code[DIGITS];

    // Active-low digit pattern, {dp,g,f,e,d,c,b,a}; anything outside 0..9 is blank.
    function automatic logic [SEG_W-1:0] digit_code(input logic [3:0] d);
        case (d)
            4'd0:    digit_code = 8'hC0;
            4'd1:    digit_code = 8'hF9;
            4'd2:    digit_code = 8'hA4;
            4'd3:    digit_code = 8'hB0;
            4'd4:    digit_code = 8'h99;
            4'd5:    digit_code = 8'h92;
            4'd6:    digit_code = 8'h82;
            4'd7:    digit_code = 8'hF8;
            4'd8:    digit_code = 8'h80;
            4'd9:    digit_code = 8'h90;
            default: digit_code = 8'hFF;
        endcase
    endfunction

    // Add-3 correction applied to every BCD nibble ahead of each shift.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
    end

    // Digit codes with leading-zero blanking scanned from the top digit down.
    always_comb begin
        logic             hi_zero;
        logic [SEG_W-1:0] raw;
        hi_zero = 1'b1;
        raw     = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            hi_zero = hi_zero && (bcd_q[4*i +: 4] == 4'd0);
            if (BLANK_LZ && hi_zero && (i != 0))
                raw = 8'hFF;
            else
                raw = digit_code(bcd_q[4*i +: 4]);
            enc_code[i] = SEG_ACTIVE_LOW ? raw : ~raw;
        end
    end

    // Next-state and datapath updates.
    always_comb begin
        state_nxt = state;
        bin_nxt   = bin_q;
        bcd_nxt   = bcd_q;
        cnt_nxt   = cnt_q;
        busy_nxt  = busy;
        done_nxt  = 1'b0;
        seg_nxt   = seg_q;
        case (state)
            IDLE: begin
                if (load) begin
                    bin_nxt   = value;
                    bcd_nxt   = '0;
                    cnt_nxt   = '0;
                    busy_nxt  = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                bcd_nxt = {bcd_adj[BCD_W-2:0], bin_q[BIN_W-1]};
                bin_nxt = {bin_q[BIN_W-2:0], 1'b0};
                cnt_nxt = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(BIN_W - 1))
                    state_nxt = ENC;
            end
            ENC: begin
                seg_nxt   = enc_code;
                done_nxt  = 1'b1;
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            bin_q <= '0;
            bcd_q <= '0;
            cnt_q <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            for (int i = 0; i < DIGITS; i++)
                seg_q[i] <= SEG_OFF;
        end else begin
            state <= state_nxt;
            bin_q <= bin_nxt;
            bcd_q <= bcd_nxt;
            cnt_q <= cnt_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
            seg_q <= seg_nxt;
        end
    end

    assign seg0 = seg_q[0];
    assign seg1 = seg_q[1];
    assign seg2 = seg_q[2];
    assign seg3 = seg_q[3];
    assign seg4 = seg_q[4];

endmodule
